// File: rtl/pipe_pkg.sv
// Shared definitions for the EX/MEM slice: datapath widths, ALU function codes
// and the widths of the fields packed into each lane of the EX/MEM register.
package pipe_pkg;

  localparam int unsigned W          = 32;
  localparam int unsigned RW         = 5;
  localparam int unsigned CTRL_MEM_W = 3;
  localparam int unsigned CTRL_WB_W  = 2;
  localparam int unsigned CTRL_W     = CTRL_MEM_W + CTRL_WB_W;
  localparam int unsigned EXMEM_W    = CTRL_W + 2 * W + RW + 2;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_NOR = 3'b101,
    ALU_SLT = 3'b110,
    ALU_SLL = 3'b111
  } alu_fun_e;

endpackage

// File: rtl/alu32.sv
// Combinational ALU for one execute lane: result, zero flag and signed
// overflow (add/sub only).
module alu32 #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [2:0]   fun,
  output logic [W-1:0] y,
  output logic         zero,
  output logic         ovf
);
  import pipe_pkg::*;

  always_comb begin
    y   = '0;
    ovf = 1'b0;
    case (fun)
      ALU_ADD: begin
        y   = A + B;
        ovf = (A[W-1] == B[W-1]) && (y[W-1] != A[W-1]);
      end
      ALU_SUB: begin
        y   = A - B;
        ovf = (A[W-1] != B[W-1]) && (y[W-1] != A[W-1]);
      end
      ALU_AND: y = A & B;
      ALU_OR:  y = A | B;
      ALU_XOR: y = A ^ B;
      ALU_NOR: y = ~(A | B);
      ALU_SLT: y = {{(W-1){1'b0}}, ($signed(A) < $signed(B))};
      ALU_SLL: y = A << B[4:0];
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/exe_mem_stage.sv
// Dual-lane execute stage: operand/destination muxing, one ALU per lane, and
// the EX/MEM pipeline register with reset > flush > stall priority.
module exe_mem_stage #(
  parameter int unsigned W  = 32,
  parameter int unsigned RW = 5
) (
  input  logic          reloj,
  input  logic          resetEX,
  input  logic          stallEX,
  input  logic          flushEX,
  input  logic [2:0]    ALU_FUN1,
  input  logic [2:0]    ALU_FUN2,
  input  logic          SEL_ALU1,
  input  logic          SEL_ALU2,
  input  logic          SEL_REG1,
  input  logic          SEL_REG2,
  input  logic [2:0]    ctrl_MEM_exe1,
  input  logic [2:0]    ctrl_MEM_exe2,
  input  logic [1:0]    ctrl_WB_exe1,
  input  logic [1:0]    ctrl_WB_exe2,
  input  logic [W-1:0]  A1,
  input  logic [W-1:0]  A2,
  input  logic [W-1:0]  DOB_exe1,
  input  logic [W-1:0]  DOB_exe2,
  input  logic [W-1:0]  imm_ext_exe1,
  input  logic [W-1:0]  imm_ext_exe2,
  input  logic [RW-1:0] rt_exe1,
  input  logic [RW-1:0] rt_exe2,
  input  logic [RW-1:0] rd_exe1,
  input  logic [RW-1:0] rd_exe2,
  output logic [W-1:0]  ALU_mem1,
  output logic [W-1:0]  ALU_mem2,
  output logic [W-1:0]  DOB_mem1,
  output logic [W-1:0]  DOB_mem2,
  output logic [RW-1:0] dest_mem1,
  output logic [RW-1:0] dest_mem2,
  output logic [2:0]    ctrl_MEM_mem1,
  output logic [2:0]    ctrl_MEM_mem2,
  output logic [1:0]    ctrl_WB_mem1,
  output logic [1:0]    ctrl_WB_mem2,
  output logic          zero_mem1,
  output logic          zero_mem2,
  output logic          ovf_mem1,
  output logic          ovf_mem2
);
  import pipe_pkg::*;

  localparam int unsigned LANE_W = CTRL_W + 2 * W + RW + 2;
  localparam int unsigned DATA_W = LANE_W - CTRL_W;

  logic [W-1:0]  b1, b2, y1, y2;
  logic [RW-1:0] dest1, dest2;
  logic          z1, z2, o1, o2;
  logic [LANE_W-1:0] lane1_d, lane2_d, lane1_q, lane2_q;

  assign b1    = SEL_ALU1 ? imm_ext_exe1 : DOB_exe1;
  assign b2    = SEL_ALU2 ? imm_ext_exe2 : DOB_exe2;
  assign dest1 = SEL_REG1 ? rd_exe1 : rt_exe1;
  assign dest2 = SEL_REG2 ? rd_exe2 : rt_exe2;

  alu32 #(.W(W)) u_alu1 (.A(A1), .B(b1), .fun(ALU_FUN1), .y(y1), .zero(z1), .ovf(o1));
  alu32 #(.W(W)) u_alu2 (.A(A2), .B(b2), .fun(ALU_FUN2), .y(y2), .zero(z2), .ovf(o2));

  // Lane layout MSB..LSB: ctrl_MEM, ctrl_WB, ALU, DOB, dest, zero, ovf
  assign lane1_d = {ctrl_MEM_exe1, ctrl_WB_exe1, y1, DOB_exe1, dest1, z1, o1};
  assign lane2_d = {ctrl_MEM_exe2, ctrl_WB_exe2, y2, DOB_exe2, dest2, z2, o2};

  // Flush only clears the control slice; data still loads and is don't-care.
  always_ff @(posedge reloj) begin
    if (resetEX) begin
      lane1_q <= '0;
      lane2_q <= '0;
    end else if (flushEX) begin
      lane1_q <= {{CTRL_W{1'b0}}, lane1_d[DATA_W-1:0]};
      lane2_q <= {{CTRL_W{1'b0}}, lane2_d[DATA_W-1:0]};
    end else if (!stallEX) begin
      lane1_q <= lane1_d;
      lane2_q <= lane2_d;
    end
  end

  assign {ctrl_MEM_mem1, ctrl_WB_mem1, ALU_mem1, DOB_mem1, dest_mem1, zero_mem1, ovf_mem1} = lane1_q;
  assign {ctrl_MEM_mem2, ctrl_WB_mem2, ALU_mem2, DOB_mem2, dest_mem2, zero_mem2, ovf_mem2} = lane2_q;

endmodule

// File: tb/tb_exe_mem_stage.sv
// Bench for exe_mem_stage: per-cycle comparison against a behavioural model,
// plus directed vectors with literal expected values.
module tb_exe_mem_stage;

  logic clk = 1'b0;
  logic rst, stall, flush;
  logic [2:0]  fun[2];
  logic        sel_alu[2], sel_reg[2];
  logic [2:0]  cmem[2];
  logic [1:0]  cwb[2];
  logic [31:0] a[2], dob[2], imm[2];
  logic [4:0]  rt[2], rd[2];

  logic [31:0] alu_o[2], dob_o[2];
  logic [4:0]  dest_o[2];
  logic [2:0]  cm_o[2];
  logic [1:0]  cw_o[2];
  logic        z_o[2], o_o[2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  exe_mem_stage #(.W(32), .RW(5)) dut (
    .reloj(clk), .resetEX(rst), .stallEX(stall), .flushEX(flush),
    .ALU_FUN1(fun[0]), .ALU_FUN2(fun[1]),
    .SEL_ALU1(sel_alu[0]), .SEL_ALU2(sel_alu[1]),
    .SEL_REG1(sel_reg[0]), .SEL_REG2(sel_reg[1]),
    .ctrl_MEM_exe1(cmem[0]), .ctrl_MEM_exe2(cmem[1]),
    .ctrl_WB_exe1(cwb[0]), .ctrl_WB_exe2(cwb[1]),
    .A1(a[0]), .A2(a[1]),
    .DOB_exe1(dob[0]), .DOB_exe2(dob[1]),
    .imm_ext_exe1(imm[0]), .imm_ext_exe2(imm[1]),
    .rt_exe1(rt[0]), .rt_exe2(rt[1]), .rd_exe1(rd[0]), .rd_exe2(rd[1]),
    .ALU_mem1(alu_o[0]), .ALU_mem2(alu_o[1]),
    .DOB_mem1(dob_o[0]), .DOB_mem2(dob_o[1]),
    .dest_mem1(dest_o[0]), .dest_mem2(dest_o[1]),
    .ctrl_MEM_mem1(cm_o[0]), .ctrl_MEM_mem2(cm_o[1]),
    .ctrl_WB_mem1(cw_o[0]), .ctrl_WB_mem2(cw_o[1]),
    .zero_mem1(z_o[0]), .zero_mem2(z_o[1]),
    .ovf_mem1(o_o[0]), .ovf_mem2(o_o[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU using wide signed integer arithmetic.
  task automatic alu_ref(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output logic ov);
    longint sx, sy, s;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ov = 1'b0;
    s  = 0;
    case (f)
      3'd0: begin s = sx + sy; r = s[31:0]; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      3'd1: begin s = sx - sy; r = s[31:0]; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: r = ~(x | y);
      3'd6: r = (sx < sy) ? 32'd1 : 32'd0;
      default: r = x << (y % 32);
    endcase
  endtask

  // Behavioural model of the registered outputs.
  logic [31:0] m_alu[2], m_dob[2];
  logic [4:0]  m_dest[2];
  logic [2:0]  m_cm[2];
  logic [1:0]  m_cw[2];
  logic        m_z[2], m_o[2], m_dc[2];
  logic        m_valid = 1'b0;

  always @(posedge clk) begin
    logic [31:0] r;
    logic ov;
    for (int l = 0; l < 2; l++) begin
      if (rst) begin
        m_alu[l] = 0; m_dob[l] = 0; m_dest[l] = 0; m_cm[l] = 0; m_cw[l] = 0;
        m_z[l] = 0; m_o[l] = 0; m_dc[l] = 0;
      end else if (flush) begin
        m_cm[l] = 0; m_cw[l] = 0; m_dc[l] = 1'b1;
      end else if (!stall) begin
        alu_ref(fun[l], a[l], sel_alu[l] ? imm[l] : dob[l], r, ov);
        m_alu[l] = r; m_o[l] = ov; m_z[l] = (r == 0);
        m_dob[l] = dob[l]; m_dest[l] = sel_reg[l] ? rd[l] : rt[l];
        m_cm[l] = cmem[l]; m_cw[l] = cwb[l]; m_dc[l] = 1'b0;
      end
    end
    if (rst) m_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      for (int l = 0; l < 2; l++) begin
        chk($sformatf("model ctrl_MEM lane%0d", l + 1), 32'(cm_o[l]), 32'(m_cm[l]));
        chk($sformatf("model ctrl_WB lane%0d", l + 1), 32'(cw_o[l]), 32'(m_cw[l]));
        if (!m_dc[l]) begin
          chk($sformatf("model ALU lane%0d", l + 1), alu_o[l], m_alu[l]);
          chk($sformatf("model DOB lane%0d", l + 1), dob_o[l], m_dob[l]);
          chk($sformatf("model dest lane%0d", l + 1), 32'(dest_o[l]), 32'(m_dest[l]));
          chk($sformatf("model zero lane%0d", l + 1), 32'(z_o[l]), 32'(m_z[l]));
          chk($sformatf("model ovf lane%0d", l + 1), 32'(o_o[l]), 32'(m_o[l]));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int l, input logic [2:0] f, input logic sa, input logic sr,
                          input logic [2:0] cm, input logic [1:0] cw, input logic [31:0] av,
                          input logic [31:0] dv, input logic [31:0] iv,
                          input logic [4:0] rtv, input logic [4:0] rdv);
    fun[l] = f; sel_alu[l] = sa; sel_reg[l] = sr; cmem[l] = cm; cwb[l] = cw;
    a[l] = av; dob[l] = dv; imm[l] = iv; rt[l] = rtv; rd[l] = rdv;
  endtask

  task automatic randomize_inputs();
    for (int l = 0; l < 2; l++)
      set_lane(l, 3'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), 2'($urandom),
               $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom));
  endtask

  task automatic chk_zero(input string tag);
    for (int l = 0; l < 2; l++) begin
      chk({tag, " ALU"}, alu_o[l], 32'd0);
      chk({tag, " DOB"}, dob_o[l], 32'd0);
      chk({tag, " dest"}, 32'(dest_o[l]), 32'd0);
      chk({tag, " ctrl_MEM"}, 32'(cm_o[l]), 32'd0);
      chk({tag, " ctrl_WB"}, 32'(cw_o[l]), 32'd0);
      chk({tag, " zero"}, 32'(z_o[l]), 32'd0);
      chk({tag, " ovf"}, 32'(o_o[l]), 32'd0);
    end
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [31:0] x, y, r;
    logic        ov;
  } vec_t;

  vec_t vecs[9] = '{
    '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1},
    '{3'd1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1},
    '{3'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0},
    '{3'd3, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0},
    '{3'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b0},
    '{3'd5, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0},
    '{3'd6, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0},
    '{3'd7, 32'h0000_0003, 32'h0000_001F, 32'h8000_0000, 1'b0},
    '{3'd1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0}
  };

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    randomize_inputs();
    tick();
    chk_zero("reset");

    // Add overflow on lane 1, sub to zero on lane 2.
    rst = 1'b0;
    set_lane(0, 3'd0, 1'b1, 1'b1, 3'b010, 2'b10, 32'h7FFF_FFFF, 32'h0000_DEAD, 32'd1, 5'd4, 5'd9);
    set_lane(1, 3'd1, 1'b0, 1'b0, 3'b001, 2'b01, 32'd5, 32'd5, 32'h99, 5'd3, 5'd7);
    tick();
    chk("add ALU1", alu_o[0], 32'h8000_0000);
    chk("add ovf1", 32'(o_o[0]), 32'd1);
    chk("add dest1", 32'(dest_o[0]), 32'd9);
    chk("add zero1", 32'(z_o[0]), 32'd0);
    chk("add ctrl_MEM1", 32'(cm_o[0]), 32'd2);
    chk("sub ALU2", alu_o[1], 32'd0);
    chk("sub zero2", 32'(z_o[1]), 32'd1);
    chk("sub ovf2", 32'(o_o[1]), 32'd0);
    chk("sub dest2", 32'(dest_o[1]), 32'd3);
    chk("sub DOB2", dob_o[1], 32'd5);

    set_lane(0, 3'd6, 1'b0, 1'b0, 3'b000, 2'b00, 32'hFFFF_FFFF, 32'd1, 32'h0, 5'd1, 5'd2);
    set_lane(1, 3'd7, 1'b1, 1'b1, 3'b000, 2'b00, 32'd1, 32'hFFFF_0000, 32'h24, 5'd1, 5'd2);
    tick();
    chk("slt ALU1", alu_o[0], 32'd1);
    chk("sll ALU2", alu_o[1], 32'h10);

    // Same vectors on both lanes; lane 2 takes B from the immediate.
    foreach (vecs[i]) begin
      set_lane(0, vecs[i].f, 1'b0, 1'b0, 3'b011, 2'b01, vecs[i].x, vecs[i].y, 32'h1234_5678, 5'(i), 5'd31);
      set_lane(1, vecs[i].f, 1'b1, 1'b1, 3'b110, 2'b10, vecs[i].x, 32'hCAFE_F00D, vecs[i].y, 5'd0, 5'(i));
      tick();
      for (int l = 0; l < 2; l++) begin
        chk($sformatf("vec%0d ALU lane%0d", i, l + 1), alu_o[l], vecs[i].r);
        chk($sformatf("vec%0d ovf lane%0d", i, l + 1), 32'(o_o[l]), 32'(vecs[i].ov));
        chk($sformatf("vec%0d dest lane%0d", i, l + 1), 32'(dest_o[l]), 32'(i));
      end
    end

    // Stall holds for three cycles; release edge loads the inputs then present.
    set_lane(0, 3'd3, 1'b0, 1'b1, 3'b001, 2'b01, 32'h0000_FFFF, 32'h00FF_0000, 32'h0, 5'd2, 5'd12);
    set_lane(1, 3'd4, 1'b1, 1'b0, 3'b100, 2'b11, 32'hAAAA_AAAA, 32'h0, 32'hFFFF_FFFF, 5'd20, 5'd21);
    tick();
    chk("pre-stall ALU1", alu_o[0], 32'h00FF_FFFF);
    chk("pre-stall ALU2", alu_o[1], 32'h5555_5555);
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      randomize_inputs();
      tick();
      chk($sformatf("stall%0d ALU1", c), alu_o[0], 32'h00FF_FFFF);
      chk($sformatf("stall%0d ALU2", c), alu_o[1], 32'h5555_5555);
      chk($sformatf("stall%0d dest1", c), 32'(dest_o[0]), 32'd12);
      chk($sformatf("stall%0d dest2", c), 32'(dest_o[1]), 32'd20);
      chk($sformatf("stall%0d ctrl_WB2", c), 32'(cw_o[1]), 32'd3);
    end
    stall = 1'b0;
    set_lane(0, 3'd0, 1'b0, 1'b0, 3'b010, 2'b10, 32'd2, 32'd3, 32'h0, 5'd1, 5'd6);
    set_lane(1, 3'd7, 1'b1, 1'b0, 3'b010, 2'b10, 32'hF, 32'h0, 32'd4, 5'd8, 5'd6);
    tick();
    chk("release ALU1", alu_o[0], 32'd5);
    chk("release ALU2", alu_o[1], 32'hF0);
    chk("release dest1", 32'(dest_o[0]), 32'd1);

    // Flush, then flush together with stall after the controls were loaded.
    for (int l = 0; l < 2; l++)
      set_lane(l, 3'd0, 1'b0, 1'b0, 3'b101, 2'b11, 32'd1, 32'd1, 32'd0, 5'd1, 5'd1);
    flush = 1'b1;
    tick();
    for (int l = 0; l < 2; l++) begin
      chk($sformatf("flush ctrl_MEM lane%0d", l + 1), 32'(cm_o[l]), 32'd0);
      chk($sformatf("flush ctrl_WB lane%0d", l + 1), 32'(cw_o[l]), 32'd0);
    end
    flush = 1'b0;
    tick();
    chk("reload ctrl_MEM1", 32'(cm_o[0]), 32'd5);
    chk("reload ctrl_WB2", 32'(cw_o[1]), 32'd3);
    flush = 1'b1; stall = 1'b1;
    tick();
    for (int l = 0; l < 2; l++) begin
      chk($sformatf("flush+stall ctrl_MEM lane%0d", l + 1), 32'(cm_o[l]), 32'd0);
      chk($sformatf("flush+stall ctrl_WB lane%0d", l + 1), 32'(cw_o[l]), 32'd0);
    end

    // Reset wins over stall and flush.
    flush = 1'b0; stall = 1'b0;
    set_lane(0, 3'd3, 1'b0, 1'b1, 3'b111, 2'b11, 32'hFFFF_FFFF, 32'h1, 32'h1, 5'd30, 5'd31);
    set_lane(1, 3'd0, 1'b1, 1'b1, 3'b111, 2'b11, 32'h8000_0000, 32'h1, 32'h8000_0000, 5'd30, 5'd31);
    tick();
    chk("pre-reset ovf2", 32'(o_o[1]), 32'd1);
    rst = 1'b1; stall = 1'b1; flush = 1'b1;
    randomize_inputs();
    tick();
    chk_zero("reset+stall+flush");
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    tick();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
